// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected output stage.
// Holds score/vector sizing defaults and the argmax reader state encoding.
package fc_pkg;

    localparam int ACC_WIDTH_DEF   = 32;
    localparam int NUM_OUTPUTS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fc_max_cmp.sv
// Signed compare-and-select: keeps the incumbent on ties so the
// lowest index wins; reusable by later pooling stages.
module fc_max_cmp #(
    parameter int W  = 32,
    parameter int IW = 4
) (
    input  logic signed [W-1:0]  i_best_val,
    input  logic        [IW-1:0] i_best_idx,
    input  logic signed [W-1:0]  i_cand_val,
    input  logic        [IW-1:0] i_cand_idx,
    output logic signed [W-1:0]  o_sel_val,
    output logic        [IW-1:0] o_sel_idx,
    output logic                 o_replace
);

    assign o_replace = i_cand_val > i_best_val;
    assign o_sel_val = o_replace ? i_cand_val : i_best_val;
    assign o_sel_idx = o_replace ? i_cand_idx : i_best_idx;

endmodule

// File: rtl/fc_argmax_reader.sv
// Captures the FC score vector on finish, scans it serially and reports argmax.
// Define FC_SCORE_STREAM_EN to expose each scanned score on a valid/ready port.
module fc_argmax_reader
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
    parameter int IDX_WIDTH   = $clog2(NUM_OUTPUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         finish,
    input  logic [NUM_OUTPUTS*ACC_WIDTH-1:0] out_vec_flat,
    output logic [IDX_WIDTH-1:0]         class_idx,
    output logic [ACC_WIDTH-1:0]         max_score,
    output logic                         done,
    output logic                         busy,
`ifdef FC_SCORE_STREAM_EN
    output logic                         score_valid,
    input  logic                         score_ready,
    output logic [ACC_WIDTH-1:0]         score_data,
    output logic [IDX_WIDTH-1:0]         score_idx,
`endif
    output logic                         overrun
);

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_OUTPUTS - 1);

    fc_state_e r_state;
    fc_state_e w_next;

    logic [NUM_OUTPUTS-1:0][ACC_WIDTH-1:0] r_buf;
    logic [ACC_WIDTH-1:0] r_best_val;
    logic [IDX_WIDTH-1:0] r_best_idx;
    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH-1:0] r_class_idx;
    logic [ACC_WIDTH-1:0] r_max_score;
    logic                 r_done;
    logic                 r_overrun;

    logic [ACC_WIDTH-1:0] w_cand;
    logic [ACC_WIDTH-1:0] w_sel_val;
    logic [IDX_WIDTH-1:0] w_sel_idx;
    logic                 w_replace;
    logic                 w_step;
    logic [IDX_WIDTH-1:0] w_ptr_start;

    assign w_cand = r_buf[r_ptr];

`ifdef FC_SCORE_STREAM_EN
    // Streaming starts at index 0; comparing score0 with itself is a no-op.
    assign w_step      = score_ready;
    assign w_ptr_start = '0;
    assign score_valid = (r_state == SCAN);
    assign score_data  = w_cand;
    assign score_idx   = r_ptr;
`else
    assign w_step      = 1'b1;
    assign w_ptr_start = IDX_WIDTH'(1);
`endif

    fc_max_cmp #(
        .W  (ACC_WIDTH),
        .IW (IDX_WIDTH)
    ) u_cmp (
        .i_best_val (r_best_val),
        .i_best_idx (r_best_idx),
        .i_cand_val (w_cand),
        .i_cand_idx (r_ptr),
        .o_sel_val  (w_sel_val),
        .o_sel_idx  (w_sel_idx),
        .o_replace  (w_replace)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (finish) w_next = SCAN;
            SCAN:    if (w_step && (r_ptr == LAST)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_ptr       <= '0;
            r_class_idx <= '0;
            r_max_score <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (finish && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (finish) begin
                        r_buf      <= out_vec_flat;
                        r_best_val <= out_vec_flat[ACC_WIDTH-1:0];
                        r_best_idx <= '0;
                        r_ptr      <= w_ptr_start;
                    end
                end
                SCAN: begin
                    if (w_step) begin
                        r_best_val <= w_sel_val;
                        r_best_idx <= w_sel_idx;
                        r_ptr      <= r_ptr + IDX_WIDTH'(1);
                    end
                end
                DONE: begin
                    r_class_idx <= r_best_idx;
                    r_max_score <= r_best_val;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign class_idx = r_class_idx;
    assign max_score = r_max_score;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Randomized bench for fc_argmax_reader against a behavioural argmax model.
// Build with FC_SCORE_STREAM_EN defined to exercise the score stream port.
module tb_fc_argmax_reader;

    localparam int AW = 32;
    localparam int N  = 10;
    localparam int IW = $clog2(N);

    typedef int sv_t [N];

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              finish = 1'b0;
    logic [N*AW-1:0]   vec    = '0;
    logic [IW-1:0]     class_idx;
    logic [AW-1:0]     max_score;
    logic              done;
    logic              busy;
    logic              overrun;
`ifdef FC_SCORE_STREAM_EN
    logic              score_valid;
    logic              score_ready = 1'b1;
    logic [AW-1:0]     score_data;
    logic [IW-1:0]     score_idx;
    bit                rdy_rand = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int t0    = 0;

    always #5 clk = ~clk;

    fc_argmax_reader #(
        .ACC_WIDTH   (AW),
        .NUM_OUTPUTS (N),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .finish       (finish),
        .out_vec_flat (vec),
        .class_idx    (class_idx),
        .max_score    (max_score),
        .done         (done),
        .busy         (busy),
`ifdef FC_SCORE_STREAM_EN
        .score_valid  (score_valid),
        .score_ready  (score_ready),
        .score_data   (score_data),
        .score_idx    (score_idx),
`endif
        .overrun      (overrun)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] mk(input sv_t s);
        logic [N*AW-1:0] v;
        for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'(s[i]);
        return v;
    endfunction

    function automatic void argmax(input logic [N*AW-1:0] v,
                                   output logic [IW-1:0] bi,
                                   output logic [AW-1:0] bv);
        bi = '0;
        bv = v[AW-1:0];
        for (int i = 1; i < N; i++) begin
            if ($signed(v[i*AW +: AW]) > $signed(bv)) begin
                bi = IW'(i);
                bv = v[i*AW +: AW];
            end
        end
    endfunction

    // Behavioural model: result due N cycles after capture (or after last handshake)
    int            cyc   = 0;
    bit            m_act = 1'b0;
    bit            m_done = 1'b0;
    bit            m_ovr = 1'b0;
    bit            bsy   = 1'b0;
    int            m_due = -1;
    int            m_k   = 0;
    logic [IW-1:0] m_idx = '0;
    logic [IW-1:0] p_idx = '0;
    logic [AW-1:0] m_score = '0;
    logic [AW-1:0] p_score = '0;
    logic [AW-1:0] m_vec [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act   = 1'b0;
            m_done  = 1'b0;
            m_ovr   = 1'b0;
            m_idx   = '0;
            m_score = '0;
            m_k     = 0;
            m_due   = -1;
        end else begin
            bsy = m_act;
            cyc++;
            m_done = 1'b0;
            if (bsy && cyc == m_due) begin
                m_act   = 1'b0;
                m_done  = 1'b1;
                m_idx   = p_idx;
                m_score = p_score;
            end
`ifdef FC_SCORE_STREAM_EN
            if (bsy && m_k < N && score_ready) begin
                m_k++;
                if (m_k == N) m_due = cyc + 1;
            end
`endif
            if (finish) begin
                if (bsy) begin
                    m_ovr = 1'b1;
                end else begin
                    m_act = 1'b1;
                    m_k   = 0;
                    argmax(vec, p_idx, p_score);
                    for (int i = 0; i < N; i++) m_vec[i] = vec[i*AW +: AW];
`ifdef FC_SCORE_STREAM_EN
                    m_due = -1;
`else
                    m_due = cyc + N;
`endif
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("done", done, m_done);
            chk("busy", busy, m_act);
            chk("overrun", overrun, m_ovr);
            chk("class_idx", class_idx, m_idx);
            chk("max_score", max_score, m_score);
`ifdef FC_SCORE_STREAM_EN
            chk("score_valid", score_valid, m_act && m_k < N);
            if (m_act && m_k < N) begin
                chk("score_idx", score_idx, IW'(m_k));
                chk("score_data", score_data, m_vec[m_k]);
            end
`endif
        end
    end

`ifdef FC_SCORE_STREAM_EN
    always @(negedge clk) begin
        score_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
`endif

    task automatic send(input logic [N*AW-1:0] v);
        finish = 1'b1;
        vec    = v;
        t0     = cyc;
        @(negedge clk);
        finish = 1'b0;
        for (int i = 0; i < N; i++) vec[i*AW +: AW] = $urandom;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " timeout"}, 64'(t < 300), 64'd1);
    endtask

    sv_t s;
    logic [N*AW-1:0] v1;
    logic [N*AW-1:0] v2;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst class_idx", class_idx, 0);
        chk("rst max_score", max_score, 0);
        chk("rst done", done, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        s  = '{3, -5, 7, 1, 7, 0, 2, -1, 6, 4};
        v1 = mk(s);
        send(v1);
        wait_done("t1");
        chk("t1 idx", class_idx, 2);
        chk("t1 max", 64'($signed(max_score)), 64'(7));
`ifndef FC_SCORE_STREAM_EN
        chk("t1 latency", 64'(cyc - t0 - 1), 64'(N));
`endif

        s  = '{-9, -2, -30, -5, -7, -100, -3, -40, -2, -11};
        v2 = mk(s);
        @(negedge clk);
        send(v2);
        wait_done("t2");
        chk("t2 idx", class_idx, 1);
        chk("t2 max", 64'($signed(max_score)), 64'(-2));

        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2147483647};
        send(mk(s));
        wait_done("t3");
        chk("t3 idx", class_idx, 9);
        chk("t3 max", 64'($signed(max_score)), 64'(2147483647));

        s = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
        send(mk(s));
        wait_done("t3b");
        chk("t3b idx", class_idx, 0);

        @(negedge clk);
        send(v1);
        repeat (3) @(negedge clk);
        send(v2);
        wait_done("t4");
        chk("t4 idx", class_idx, 2);
        chk("t4 overrun", overrun, 1);
        @(negedge clk);
        send(v2);
        wait_done("t4b");
        chk("t4b idx", class_idx, 1);
        chk("t4b overrun", overrun, 1);

        @(negedge clk);
        send(v2);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst busy", busy, 0);
        chk("mid-rst done", done, 0);
        chk("mid-rst idx", class_idx, 0);
        chk("mid-rst max", max_score, 0);
        chk("mid-rst overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        send(v1);
        wait_done("t5");
        chk("t5 idx", class_idx, 2);

`ifdef FC_SCORE_STREAM_EN
        rdy_rand = 1'b1;
`endif
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) s[i] = int'($urandom_range(0, 6)) - 3;
                else            s[i] = int'($urandom);
            end
            send(mk(s));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                send(mk(s));
            end
            wait_done("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
